// File: rtl/matrix_bram_pkg.sv
// Shared types for the matrix BRAM blocks: fill modes, filler FSM states and
// the default metadata size.
package matrix_bram_pkg;

  localparam int META_WORDS_DEFAULT = 3;

  typedef enum logic [1:0] {
    MODE_META  = 2'd0,
    MODE_FULL  = 2'd1,
    MODE_RANGE = 2'd2
  } fill_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } filler_state_t;

endpackage

// File: rtl/matrix_block_filler_if.sv
// Request / completion / BRAM-write bundle between the BRAM manager, the
// block filler and the BRAM arbiter.
interface matrix_block_filler_if #(
  parameter int ID_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ID_WIDTH-1:0]   req_matrix_id;
  logic [1:0]            req_mode;
  logic [ADDR_WIDTH-1:0] req_offset;
  logic [ADDR_WIDTH:0]   req_len;
  logic [DATA_WIDTH-1:0] req_fill;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  done_error;
  logic                  done_aborted;
  logic [ADDR_WIDTH:0]   done_count;
  logic                  bram_wr_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_wr_ready;

  modport slave (
    input  req_valid, req_matrix_id, req_mode, req_offset, req_len, req_fill,
           abort, bram_wr_ready,
    output req_ready, busy, done, done_error, done_aborted, done_count,
           bram_wr_en, bram_addr, bram_din
  );

  modport master (
    output req_valid, req_matrix_id, req_mode, req_offset, req_len, req_fill,
           abort, bram_wr_ready,
    input  req_ready, busy, done, done_error, done_aborted, done_count,
           bram_wr_en, bram_addr, bram_din
  );
endinterface

// File: rtl/matrix_block_filler_address_getter.sv
// Base address of a matrix block: id * BLOCK_SIZE, one bit wider than the
// BRAM address so out-of-range ids do not silently wrap.
module matrix_address_getter #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic [ADDR_WIDTH-1:0] matrix_id,
  output logic [ADDR_WIDTH:0]   base_addr
);
  localparam int          AW1 = ADDR_WIDTH + 1;
  localparam logic [31:0] BS  = 32'(BLOCK_SIZE);

  assign base_addr = AW1'(32'(matrix_id) * BS);
endmodule

// File: rtl/matrix_block_filler.sv
// Fills a matrix block (metadata only, whole block, or a word range) through
// a valid/ready BRAM write port; one request at a time.
module matrix_block_filler
  import matrix_bram_pkg::*;
#(
  parameter int BLOCK_SIZE   = 1152,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_MATRICES = 8,
  parameter int ID_WIDTH     = 3,
  parameter int META_WORDS   = META_WORDS_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  matrix_block_filler_if.slave bus
);
  localparam int              AW1      = ADDR_WIDTH + 1;
  localparam int              AW2      = ADDR_WIDTH + 2;
  localparam logic [AW1-1:0]  BLK_LEN  = AW1'(BLOCK_SIZE);
  localparam logic [AW1-1:0]  META_LEN = AW1'(META_WORDS);
  localparam logic [AW2-1:0]  BLK_END  = AW2'(BLOCK_SIZE);
  localparam logic [31:0]     NUM_M    = 32'(NUM_MATRICES);
  localparam logic [AW1-1:0]  ONE_C    = AW1'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  filler_state_t         state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] off_q;
  logic [AW1-1:0]        len_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [AW1-1:0]        rem_q, cnt_q, rel_q;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  done_q, err_q, abt_q;
  logic [AW1-1:0]        dcnt_q;

  logic [AW1-1:0]        base;
  logic [AW1-1:0]        off_eff, len_eff;
  logic [AW2-1:0]        end_eff;
  logic                  req_bad;

  matrix_address_getter #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_get (
    .matrix_id(ADDR_WIDTH'(id_q)),
    .base_addr(base)
  );

  // Block-relative word index decides whether a FULL fill is still inside
  // the metadata header.
  function automatic logic [DATA_WIDTH-1:0] word_data(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] fill,
    input logic [AW1-1:0]        rel
  );
    if (mode == MODE_META) return '0;
    if (mode == MODE_FULL && rel < META_LEN) return '0;
    return fill;
  endfunction

  always_comb begin
    off_eff = {1'b0, off_q};
    len_eff = len_q;
    if (mode_q == MODE_META) begin
      off_eff = '0;
      len_eff = META_LEN;
    end else if (mode_q == MODE_FULL) begin
      off_eff = '0;
      len_eff = BLK_LEN;
    end
    end_eff = {1'b0, off_eff} + {1'b0, len_eff};
    req_bad = (32'(id_q) >= NUM_M) || (mode_q == 2'd3) ||
              (len_eff == '0) || (end_eff > BLK_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      id_q    <= '0;
      mode_q  <= '0;
      off_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            id_q   <= bus.req_matrix_id;
            mode_q <= bus.req_mode;
            off_q  <= bus.req_offset;
            len_q  <= bus.req_len;
            fill_q <= bus.req_fill;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (req_bad) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            abt_q  <= 1'b0;
            dcnt_q <= '0;
            state  <= ST_DONE;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= ADDR_WIDTH'(base + off_eff);
            din_q   <= word_data(mode_q, fill_q, off_eff);
            rem_q   <= len_eff;
            rel_q   <= off_eff;
            cnt_q   <= '0;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.bram_wr_ready) begin
            addr_q <= addr_q + ONE_A;
            rel_q  <= rel_q + ONE_C;
            din_q  <= word_data(mode_q, fill_q, rel_q + ONE_C);
            rem_q  <= rem_q - ONE_C;
            cnt_q  <= cnt_q + ONE_C;
          end
          // Final beat wins over a simultaneous abort: the fill is complete.
          if (bus.bram_wr_ready && rem_q == ONE_C) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            abt_q   <= 1'b0;
            dcnt_q  <= cnt_q + ONE_C;
            state   <= ST_DONE;
          end else if (bus.abort) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            abt_q   <= 1'b1;
            dcnt_q  <= bus.bram_wr_ready ? cnt_q + ONE_C : cnt_q;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          abt_q  <= 1'b0;
          dcnt_q <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.bram_wr_en   = wr_en_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_din     = din_q;
  assign bus.done         = done_q;
  assign bus.done_error   = err_q;
  assign bus.done_aborted = abt_q;
  assign bus.done_count   = dcnt_q;
endmodule

// File: tb/tb_matrix_block_filler.sv
// Bench for matrix_block_filler: a word-list model of each request checked
// every cycle by one monitor, directed cases plus randomized traffic.
module tb_matrix_block_filler;
  localparam int BLOCK = 1152, DW = 32, AW = 14, NM = 8, IDW = 4, MW = 3;
  localparam int LW = AW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_block_filler_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  matrix_block_filler #(
    .BLOCK_SIZE(BLOCK), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_MATRICES(NM), .ID_WIDTH(IDW), .META_WORDS(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int passes = 0, total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  // model of the request in flight
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit mon_on = 0, in_op = 0, xfer_open = 0;
  bit exp_err, exp_ab;
  int exp_cnt, acc, first_wr_due = 0, done_due = 0;
  int first_addr, last_addr, cyc = 0, acc_cyc, done_cyc;
  logic [31:0] first_data, last_data;
  int obs_cnt;
  bit obs_err, obs_ab;
  int rdy_mode = 0;
  bit force_lo = 0, abort_arm = 0;

  always @(posedge clk) cyc++;

  // ready/abort stimulus, changed just after each active edge
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: bus.bram_wr_ready = 1'b1;
      1: bus.bram_wr_ready = cyc[0];
      default: bus.bram_wr_ready = 1'($urandom_range(0, 1));
    endcase
    if (force_lo) bus.bram_wr_ready = 1'b0;
    bus.abort = abort_arm;
  end

  always @(negedge clk) begin : mon
    bit due_now, last;
    if (mon_on) begin
      due_now = (done_due == 1);
      if (done_due > 0) done_due--;
      if (first_wr_due > 0) begin
        first_wr_due--;
        if (first_wr_due == 0) xfer_open = 1;
      end
      chk("busy", bus.busy, in_op);
      chk("req_ready", bus.req_ready, !in_op);
      chk("wr_en", bus.bram_wr_en, xfer_open);
      if (xfer_open && exp_addr.size() > 0) begin
        chk("addr", bus.bram_addr, exp_addr[0]);
        chk("din", bus.bram_din, exp_data[0]);
        if (bus.bram_wr_ready) begin
          acc++;
          if (acc == 1) begin first_addr = exp_addr[0]; first_data = exp_data[0]; end
          last_addr = exp_addr[0];
          last_data = exp_data[0];
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
        last = (exp_addr.size() == 0);
        if (last || bus.abort) begin
          xfer_open = 0;
          exp_cnt   = acc;
          exp_ab    = !last;
          done_due  = 1;
        end
      end
      chk("done", bus.done, due_now);
      if (due_now) begin
        chk("done_error", bus.done_error, exp_err);
        chk("done_aborted", bus.done_aborted, exp_ab);
        chk("done_count", bus.done_count, exp_cnt);
        obs_cnt  = int'(bus.done_count);
        obs_err  = bus.done_error;
        obs_ab   = bus.done_aborted;
        done_cyc = cyc;
        in_op    = 0;
      end
    end
  end

  task automatic issue(input int id, input int mode, input int off, input int len,
                       input logic [31:0] fill);
    int eo, el;
    @(posedge clk); #1;
    bus.req_valid     = 1'b1;
    bus.req_matrix_id = IDW'(id);
    bus.req_mode      = 2'(mode);
    bus.req_offset    = AW'(off);
    bus.req_len       = LW'(len);
    bus.req_fill      = fill;
    @(posedge clk); #1;
    bus.req_valid     = 1'b0;
    bus.req_matrix_id = IDW'($urandom);
    bus.req_mode      = 2'($urandom);
    bus.req_offset    = AW'($urandom);
    bus.req_len       = LW'($urandom);
    bus.req_fill      = $urandom;
    acc_cyc = cyc;
    eo = (mode == 2) ? off : 0;
    el = (mode == 0) ? MW : (mode == 1) ? BLOCK : len;
    exp_addr.delete();
    exp_data.delete();
    acc = 0;
    exp_err = (id >= NM) || (mode == 3) || (el == 0) || (eo + el > BLOCK);
    if (exp_err) begin
      exp_cnt = 0; exp_ab = 0; done_due = 2;
    end else begin
      for (int i = 0; i < el; i++) begin
        exp_addr.push_back(id * BLOCK + eo + i);
        exp_data.push_back((mode == 0 || (mode == 1 && eo + i < MW)) ? 32'h0 : fill);
      end
      first_wr_due = 2;
    end
    in_op = 1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((in_op || done_due > 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (in_op) begin
      total++;
      $display("FAIL timeout: request still open after %0d cycles", budget);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
    end
  endtask

  task automatic pulse_abort(input int after_edges, input bit stall);
    repeat (after_edges) @(posedge clk);
    @(negedge clk);
    abort_arm = 1; force_lo = stall;
    @(negedge clk);
    abort_arm = 0; force_lo = 0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_matrix_id = '0; bus.req_mode = '0;
    bus.req_offset = '0; bus.req_len = '0; bus.req_fill = '0;
    bus.abort = 0; bus.bram_wr_ready = 1;
    #2;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_en", bus.bram_wr_en, 0);
    chk("rst_outs", {bus.bram_addr, bus.bram_din, bus.done, bus.done_error,
                     bus.done_aborted, bus.done_count}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    mon_on = 1;

    // META id 2: 2304..2306 <- 0, done at E+5
    rdy_mode = 0;
    issue(2, 0, 0, 0, 32'h12345678);
    wait_idle(100);
    chk("meta_first_addr", first_addr, 2304);
    chk("meta_last_addr", last_addr, 2306);
    chk("meta_count", obs_cnt, 3);
    chk("meta_latency", done_cyc - acc_cyc, 4);

    // FULL id 0: header zeroed, rest filled
    issue(0, 1, 0, 0, 32'hDEADBEEF);
    wait_idle(3000);
    chk("full_count", obs_cnt, 1152);
    chk("full_first", {first_addr, first_data}, {32'd0, 32'h0});
    chk("full_last", {last_addr, last_data}, {32'd1151, 32'hDEADBEEF});

    // RANGE id 7 with ready toggling
    rdy_mode = 1;
    issue(7, 2, 1000, 152, 32'hA5A5_0001);
    wait_idle(1000);
    chk("range_first_addr", first_addr, 9064);
    chk("range_last_addr", last_addr, 9215);
    chk("range_count", obs_cnt, 152);

    // RANGE over the metadata area keeps fill
    rdy_mode = 0;
    issue(3, 2, 1, 4, 32'h0BAD_F00D);
    wait_idle(100);
    chk("range_meta_data", {first_addr, first_data}, {32'd3457, 32'h0BAD_F00D});

    // rejected requests: done at E+2, no writes
    issue(1, 2, 1100, 53, 32'h1);
    wait_idle(100);
    chk("err_end_flag", {obs_err, obs_cnt}, {1'b1, 32'd0});
    chk("err_end_latency", done_cyc - acc_cyc, 1);
    issue(8, 2, 0, 4, 32'h2);
    wait_idle(100);
    chk("err_id_flag", obs_err, 1);
    issue(0, 2, 5, 0, 32'h3);
    wait_idle(100);
    chk("err_len0_flag", obs_err, 1);
    issue(0, 3, 0, 4, 32'h4);
    wait_idle(100);
    chk("err_mode3_flag", obs_err, 1);
    issue(6, 2, 1100, 52, 32'h5);
    wait_idle(200);
    chk("edge_range_ok", {obs_err, obs_cnt}, {1'b0, 32'd52});

    // abort on the 10th accepted beat
    issue(1, 1, 0, 0, 32'hCAFE0000);
    pulse_abort(9, 0);
    wait_idle(100);
    chk("abort_flag", obs_ab, 1);
    chk("abort_count", obs_cnt, 10);
    chk("abort_last_addr", last_addr, 1161);

    // abort during a forced stall: dropped beat not counted
    issue(3, 1, 0, 0, 32'hCAFE0001);
    pulse_abort(4, 1);
    wait_idle(100);
    chk("stall_abort", {obs_ab, obs_cnt}, {1'b1, 32'd4});
    chk("stall_abort_last", last_addr, 3459);

    // reset mid-WRITE
    rdy_mode = 2;
    issue(4, 1, 0, 0, 32'h7777_7777);
    repeat (20) @(negedge clk);
    mon_on = 0;
    #1 rst_n = 0;
    #1;
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_outs", {bus.busy, bus.bram_wr_en, bus.bram_addr, bus.bram_din, bus.done,
                        bus.done_error, bus.done_aborted, bus.done_count}, '0);
    in_op = 0; xfer_open = 0; done_due = 0; first_wr_due = 0;
    exp_addr.delete(); exp_data.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", bus.done, 0);
    end
    rst_n = 1;
    mon_on = 1;
    rdy_mode = 0;
    issue(5, 0, 0, 0, 32'hFFFF_FFFF);
    wait_idle(100);
    chk("post_rst_meta", {first_addr, obs_cnt}, {32'd5760, 32'd3});
    chk("post_rst_latency", done_cyc - acc_cyc, 4);

    // randomized traffic
    rdy_mode = 2;
    for (int r = 0; r < 12; r++) begin
      int mode, id, off, len, room;
      mode = $urandom_range(0, 3);
      id   = $urandom_range(0, 9);
      off  = $urandom_range(0, BLOCK - 1);
      room = BLOCK - off;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 200);
      else len = (room > 64) ? $urandom_range(1, 64) : $urandom_range(1, room);
      issue(id, mode, off, len, $urandom);
      if ($urandom_range(0, 2) == 0) pulse_abort($urandom_range(1, 30), 1'($urandom_range(0, 1)));
      wait_idle(6000);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
